fx_addsub_arb: RTL
==================

FX_ADDSUB_ARB -- requirements
Module: fx_addsub_arb

Interface
REQ-001 SHALL have parameter PRIO_RESET, default 0, selecting the requester that holds round-robin priority after reset (0 or 1).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester N operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  16  signed Q-format operands, two's complement.
REQ-007 SHALL have ports req0_op / req1_op  input  1  operation select: 0 = add (a+b), 1 = subtract (a-b).
REQ-008 SHALL have port resp_valid  output  1  result register holds a valid result.
REQ-009 SHALL have port resp_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port resp_data  output  16  saturated result.
REQ-011 SHALL have port resp_id  output  1  index of the requester that issued the result.
REQ-012 SHALL have port resp_sat  output  1  set when the result was clamped.
REQ-013 SHALL have port op_cnt  output  16  count of accepted operations.

Function
REQ-014 SHALL transfer a request when reqN_valid and reqN_ready are both high on a rising edge, and a response when resp_valid and resp_ready are both high.
REQ-015 SHALL compute can_accept = !resp_valid || resp_ready; reqN_ready SHALL be combinational, high only for the granted requester when can_accept is high, and low for both requesters otherwise.
REQ-016 SHALL grant the only valid requester when one is valid; when both are valid, SHALL grant the requester holding priority.
REQ-017 SHALL move priority to the non-granted requester after every accepted request; priority SHALL stay unchanged when nothing is accepted.
REQ-018 SHALL compute result = clamp(a op b, -32768, +32767) at 17-bit precision: positive overflow -> 0x7FFF, negative overflow -> 0x8000.
REQ-019 SHALL apply REQ-018 to b = 0x8000 with subtract: result is a+32768 clamped, e.g. 0x0000-0x8000 -> 0x7FFF and 0xFFFF-0x8000 -> 0x7FFF.
REQ-020 SHALL register the result, id and sat flag on acceptance: a request accepted at edge T drives resp_valid high after edge T, with one cycle of latency.
REQ-021 SHALL hold resp_data, resp_id and resp_sat stable while resp_valid=1 and resp_ready=0.
REQ-022 SHALL support a simultaneous drain and accept in one cycle: with resp_ready held high, throughput is one operation per cycle and resp_valid stays high.
REQ-023 SHALL clear resp_valid on a drain when no new request is accepted in the same cycle.
REQ-024 SHALL increment op_cnt by 1 per accepted request, wrapping from 0xFFFF to 0x0000.
REQ-025 SHALL ignore operand and op changes while reqN_ready=0.

Reset
REQ-026 SHALL, on rst high and regardless of clk, set resp_valid=0, resp_data=0x0000, resp_id=0, resp_sat=0, op_cnt=0x0000 and priority=PRIO_RESET.
REQ-027 SHALL drive req0_ready=0 and req1_ready=0 while rst is high.
REQ-028 SHALL discard any pending undrained result when reset is asserted mid-operation; no response for it SHALL appear after release.
REQ-029 SHALL accept requests in the first cycle after rst deasserts.

Structure
REQ-030 SHALL take FX_W=16, OP_ADD=1'b0, OP_SUB=1'b1, FX_MAX=16'h7FFF and FX_MIN=16'h8000 from shared package fx_pkg.
REQ-031 SHALL instantiate exactly one combinational sub-module, fx_sat_addsub (a, b, op -> result, sat), shared by both requesters through the grant mux.
REQ-032 SHALL keep all sequential state in fx_addsub_arb: priority bit, result register and op_cnt.

Verification
REQ-033 SHALL cover a single add: req0 a=0x1000, b=0x0234, op=0, resp_ready=1 -> next cycle resp_valid=1, data=0x1234, id=0, sat=0, op_cnt=1.
REQ-034 SHALL cover saturation: req1 add 0x7000+0x2000 -> 0x7FFF, sat=1; sub 0x8001-0x0002 -> 0x8000, sat=1; sub 0x0000-0x8000 -> 0x7FFF, sat=1.
REQ-035 SHALL cover round-robin: both valid continuously, PRIO_RESET=0, resp_ready=1 -> resp_id sequence 0,1,0,1 with one result per cycle.
REQ-036 SHALL cover backpressure: resp_ready=0 for 5 cycles with both requesters valid -> one result held stable, both ready low, op_cnt unchanged; resp_ready=1 -> drain and accept in the same cycle.
REQ-037 SHALL cover reset mid-operation: rst asserted with resp_valid=1 and resp_ready=0 -> resp_valid=0 and op_cnt=0 immediately (asynchronously), and no stale response after release.
REQ-038 SHALL cover counter wrap: 65536 accepted ops -> op_cnt returns to 0x0000.

Source files
------------

// File: rtl/fx_pkg.sv
// Shared fixed-point definitions for the add/subtract arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fx_pkg;

    localparam int FX_W = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [FX_W-1:0] FX_MAX = 16'h7FFF;
    localparam logic [FX_W-1:0] FX_MIN = 16'h8000;

    // Contents of the result register
    typedef struct packed {
        logic [FX_W-1:0] data;
        logic            id;
        logic            sat;
    } resp_t;

endpackage

// File: rtl/fx_sat_addsub.sv
// Saturating signed add/subtract of two Q-format operands.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result follows the inputs.
//
// Ports: a, b   - two's complement operands
//        op     - OP_ADD (a+b) or OP_SUB (a-b)
//        result - value clamped to [FX_MIN, FX_MAX]
//        sat    - high when clamping took place
module fx_sat_addsub
    import fx_pkg::*;
(
    input  logic [FX_W-1:0] a,
    input  logic [FX_W-1:0] b,
    input  logic            op,
    output logic [FX_W-1:0] result,
    output logic            sat
);

    logic [FX_W:0] a_x;
    logic [FX_W:0] b_x;
    logic [FX_W:0] sum;

    always_comb begin
        // One guard bit is enough to hold any sum or difference exactly,
        // including a - 0x8000.
        a_x = {a[FX_W-1], a};
        b_x = {b[FX_W-1], b};
        sum = (op == OP_SUB) ? (a_x - b_x) : (a_x + b_x);

        // The result fits in FX_W bits only when the guard and sign bits agree.
        sat = sum[FX_W] ^ sum[FX_W-1];
        if (sat) begin
            result = sum[FX_W] ? FX_MIN : FX_MAX;
        end else begin
            result = sum[FX_W-1:0];
        end
    end

endmodule

// File: rtl/fx_addsub_arb.sv
// Two-requester round-robin arbiter in front of a shared saturating add/sub unit.
// Latency: one cycle from an accepted request to resp_valid.
// Backpressure: both readies drop while an undrained result is held and resp_ready is low.
//
// Ports: clk, rst (async, active-high)
//        req0_* / req1_* - valid/ready request channels with operands a, b and op
//        resp_*          - valid/ready result channel with data, requester id and sat flag
//        op_cnt          - free-running count of accepted operations (wraps)
module fx_addsub_arb
    import fx_pkg::*;
#(
    parameter logic PRIO_RESET = 1'b0
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [FX_W-1:0] req0_a,
    input  logic [FX_W-1:0] req0_b,
    input  logic            req0_op,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [FX_W-1:0] req1_a,
    input  logic [FX_W-1:0] req1_b,
    input  logic            req1_op,

    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [FX_W-1:0] resp_data,
    output logic            resp_id,
    output logic            resp_sat,

    output logic [FX_W-1:0] op_cnt
);

    logic            prio_q,       prio_d;
    logic            resp_valid_q, resp_valid_d;
    resp_t           resp_q,       resp_d;
    logic [FX_W-1:0] op_cnt_q,     op_cnt_d;

    logic            can_accept;
    logic            gnt_sel;
    logic            accept;
    logic [FX_W-1:0] mux_a;
    logic [FX_W-1:0] mux_b;
    logic            mux_op;
    logic [FX_W-1:0] alu_res;
    logic            alu_sat;

    // Grant and handshake
    always_comb begin
        // Priority only matters on contention; otherwise the lone valid
        // requester wins (defaults to 0 when neither is valid, harmless
        // since ready also requires valid).
        if (req0_valid && req1_valid) begin
            gnt_sel = prio_q;
        end else begin
            gnt_sel = req1_valid;
        end

        // The result register can take a new value if it is empty or is
        // being drained on this same edge.
        can_accept = !resp_valid_q || resp_ready;

        req0_ready = !rst && can_accept && req0_valid && !gnt_sel;
        req1_ready = !rst && can_accept && req1_valid &&  gnt_sel;
        accept     = req0_ready || req1_ready;

        mux_a  = gnt_sel ? req1_a  : req0_a;
        mux_b  = gnt_sel ? req1_b  : req0_b;
        mux_op = gnt_sel ? req1_op : req0_op;
    end

    fx_sat_addsub u_alu (
        .a      (mux_a),
        .b      (mux_b),
        .op     (mux_op),
        .result (alu_res),
        .sat    (alu_sat)
    );

    // Next state
    always_comb begin
        prio_d       = prio_q;
        resp_valid_d = resp_valid_q;
        resp_d       = resp_q;
        op_cnt_d     = op_cnt_q;

        if (accept) begin
            prio_d       = ~gnt_sel;
            resp_valid_d = 1'b1;
            resp_d       = '{data: alu_res, id: gnt_sel, sat: alu_sat};
            op_cnt_d     = op_cnt_q + 1'b1;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q       <= PRIO_RESET;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
            op_cnt_q     <= '0;
        end else begin
            prio_q       <= prio_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
            op_cnt_q     <= op_cnt_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_q.data;
    assign resp_id    = resp_q.id;
    assign resp_sat   = resp_q.sat;
    assign op_cnt     = op_cnt_q;

endmodule
